// File: rtl/hidden_pkg.sv
// Shared constants, FSM state type and saturation helper for the 8-neuron hidden layer.
package hidden_pkg;

    localparam int N_NEURON  = 8;
    localparam int N_IN      = 4;
    localparam int IN_W      = 8;
    localparam int W_W       = 8;
    localparam int ACC_W     = 18;
    localparam int X_W       = 10;
    localparam int FRAC_BITS = 7;
    localparam int X_MAX     = 1023;
    localparam int BIAS_BASE = 32;

    localparam int N_W       = N_NEURON * N_IN;
    localparam int CNT_W     = $clog2(N_W);
    localparam int ADDR_W    = 6;
    localparam int PROD_W    = IN_W + W_W;
    localparam int SCALED_W  = ACC_W - FRAC_BITS;
    localparam int BIASED_W  = SCALED_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_e;

    function automatic logic [X_W-1:0] sat_x(input logic [BIASED_W-1:0] v);
        return (v > BIASED_W'(X_MAX)) ? X_W'(X_MAX) : v[X_W-1:0];
    endfunction

endpackage

// File: rtl/hidden_mac.sv
// Single 8x8 multiply-accumulate lane with combinational scale / bias / saturate path.
module hidden_mac
    import hidden_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [IN_W-1:0] in_i,
    input  logic [W_W-1:0]  w_i,
    input  logic [W_W-1:0]  bias_i,
    output logic [X_W-1:0]  x_o
);

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [PROD_W-1:0]   prod;
    logic [SCALED_W-1:0] scaled;
    logic [BIASED_W-1:0] biased;

    // acc_d already includes this cycle's product, so the neuron's last edge
    // can write the finished activation without waiting for acc_q.
    always_comb begin
        prod   = PROD_W'(in_i) * PROD_W'(w_i);
        acc_d  = (clr_i ? '0 : acc_q) + ACC_W'(prod);
        scaled = acc_d[ACC_W-1:FRAC_BITS];
        biased = BIASED_W'(scaled) + BIASED_W'(bias_i);
        x_o    = sat_x(biased);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/hidden_layer_seq.sv
// Sequential hidden layer: 8 neurons x 4 inputs over 32 MAC cycles on one multiplier.
// Optional bias storage is built only when HIDDEN_BIAS_EN is defined.
module hidden_layer_seq
    import hidden_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [IN_W-1:0]   in0_i,
    input  logic [IN_W-1:0]   in1_i,
    input  logic [IN_W-1:0]   in2_i,
    input  logic [IN_W-1:0]   in3_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [W_W-1:0]    wr_data_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [X_W-1:0]    x0_o,
    output logic [X_W-1:0]    x1_o,
    output logic [X_W-1:0]    x2_o,
    output logic [X_W-1:0]    x3_o,
    output logic [X_W-1:0]    x4_o,
    output logic [X_W-1:0]    x5_o,
    output logic [X_W-1:0]    x6_o,
    output logic [X_W-1:0]    x7_o
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IN_W-1:0]  in_q [N_IN];
    logic [W_W-1:0]   w_q  [N_W];
    logic [X_W-1:0]   x_q  [N_NEURON];
    logic             busy_q;
    logic             valid_q;

    logic             start_acc;
    logic             mac_en;
    logic             wr_ok;
    logic             wr_is_w;
    logic             last_mac;
    logic             neuron_end;
    logic [2:0]       nrn;
    logic [1:0]       jdx;
    logic [W_W-1:0]   bias_sel;
    logic [X_W-1:0]   mac_x;

    assign nrn = cnt_q[CNT_W-1:2];
    assign jdx = cnt_q[1:0];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        mac_en    = 1'b0;
        wr_ok     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ok = wr_en_i;
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (cnt_q == CNT_W'(N_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign last_mac   = mac_en && (cnt_q == CNT_W'(N_W - 1));
    assign neuron_end = mac_en && (jdx == 2'(N_IN - 1));
    assign wr_is_w    = wr_ok && (wr_addr_i < ADDR_W'(BIAS_BASE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= last_mac;
            if (start_acc) begin
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (mac_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_mac) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < N_IN; j++) begin
                in_q[j] <= '0;
            end
        end else if (start_acc) begin
            in_q[0] <= in0_i;
            in_q[1] <= in1_i;
            in_q[2] <= in2_i;
            in_q[3] <= in3_i;
        end
    end

    // NOTE: the parameter memory is reset as a whole because a cleared layer
    // must evaluate to zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_W; i++) begin
                w_q[i] <= '0;
            end
        end else if (wr_is_w) begin
            w_q[wr_addr_i[CNT_W-1:0]] <= wr_data_i;
        end
    end

`ifdef HIDDEN_BIAS_EN
    logic           wr_is_b;
    logic [W_W-1:0] b_q [N_NEURON];

    assign wr_is_b = wr_ok && (wr_addr_i >= ADDR_W'(BIAS_BASE))
                           && (wr_addr_i <  ADDR_W'(BIAS_BASE + N_NEURON));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < N_NEURON; n++) begin
                b_q[n] <= '0;
            end
        end else if (wr_is_b) begin
            b_q[wr_addr_i[2:0]] <= wr_data_i;
        end
    end

    assign bias_sel = b_q[nrn];
`else
    assign bias_sel = '0;
`endif

    hidden_mac u_mac (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (mac_en),
        .clr_i  (jdx == 2'd0),
        .in_i   (in_q[jdx]),
        .w_i    (w_q[cnt_q]),
        .bias_i (bias_sel),
        .x_o    (mac_x)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < N_NEURON; n++) begin
                x_q[n] <= '0;
            end
        end else if (neuron_end) begin
            x_q[nrn] <= mac_x;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign x0_o    = x_q[0];
    assign x1_o    = x_q[1];
    assign x2_o    = x_q[2];
    assign x3_o    = x_q[3];
    assign x4_o    = x_q[4];
    assign x5_o    = x_q[5];
    assign x6_o    = x_q[6];
    assign x7_o    = x_q[7];

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Scoreboard bench for hidden_layer_seq; expectations follow HIDDEN_BIAS_EN when defined.
module tb_hidden_layer_seq;

    typedef logic [7:0][9:0] xvec_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] in0_i, in1_i, in2_i, in3_i;
    logic       wr_en_i;
    logic [5:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       busy_o, valid_o;
    logic [9:0] x0_o, x1_o, x2_o, x3_o, x4_o, x5_o, x6_o, x7_o;
    xvec_t      x_obs;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    w_m [32];
    int    b_m [8];
    xvec_t sb_q [$];
    xvec_t last_exp;

    always #5 clk = ~clk;

    hidden_layer_seq dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .in0_i     (in0_i),
        .in1_i     (in1_i),
        .in2_i     (in2_i),
        .in3_i     (in3_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .x0_o      (x0_o),
        .x1_o      (x1_o),
        .x2_o      (x2_o),
        .x3_o      (x3_o),
        .x4_o      (x4_o),
        .x5_o      (x5_o),
        .x6_o      (x6_o),
        .x7_o      (x7_o)
    );

    assign x_obs = {x7_o, x6_o, x5_o, x4_o, x3_o, x2_o, x1_o, x0_o};

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_x(input int n, input int i0, input int i1, input int i2, input int i3);
        int s;
        s = i0 * w_m[n*4] + i1 * w_m[n*4+1] + i2 * w_m[n*4+2] + i3 * w_m[n*4+3];
        s = s / 128;
`ifdef HIDDEN_BIAS_EN
        s = s + b_m[n];
`endif
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic push_expected(input int i0, input int i1, input int i2, input int i3);
        xvec_t e;
        for (int n = 0; n < 8; n++) begin
            e[n] = 10'(model_x(n, i0, i1, i2, i3));
        end
        sb_q.push_back(e);
    endtask

    task automatic model_write(input int a, input int d);
        if (a < 32) begin
            w_m[a] = d;
        end else if (a < 40) begin
`ifdef HIDDEN_BIAS_EN
            b_m[a-32] = d;
`endif
        end
    endtask

    // Scoreboard consumer: every valid pulse pops one expected result.
    always @(negedge clk) begin
        if (valid_o && !rst_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 80'd1, 80'd0);
            end else begin
                last_exp = sb_q.pop_front();
                check("x_vector", x_obs, last_exp);
            end
        end
    end

    // All tasks below start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) w_m[i] = 0;
        for (int n = 0; n < 8; n++) b_m[n] = 0;
        sb_q.delete();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en_i   = 1'b1;
        wr_addr_i = 6'(a);
        wr_data_i = 8'(d);
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
        model_write(a, d);
    endtask

    task automatic write_all_w(input int d);
        for (int i = 0; i < 32; i++) wr(i, d);
    endtask

    task automatic start_run(input int i0, input int i1, input int i2, input int i3,
                             input bit with_wr, input int wa, input int wd);
        in0_i   = 8'(i0);
        in1_i   = 8'(i1);
        in2_i   = 8'(i2);
        in3_i   = 8'(i3);
        start_i = 1'b1;
        if (with_wr) begin
            wr_en_i   = 1'b1;
            wr_addr_i = 6'(wa);
            wr_data_i = 8'(wd);
            model_write(wa, wd);
        end
        push_expected(i0, i1, i2, i3);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wr_en_i = 1'b0;
    endtask

    // Cycles are numbered from 1 = the cycle after the start-accepting edge.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy_o) busy_cycles++;
            if (valid_o) begin
                cycles = c;
                break;
            end
        end
        if (cycles == 0) check("done_timeout", 80'd0, 80'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, bcyc, v1, v2, nval;
        start_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        in0_i = '0; in1_i = '0; in2_i = '0; in3_i = '0;
        do_reset();

        check("reset_busy", 80'(busy_o), 80'd0);
        check("reset_valid", 80'(valid_o), 80'd0);
        check("reset_x", x_obs, 80'd0);

        // Unity weights: (10+20+30+40)*1.0 = 100 on every neuron.
        write_all_w(8'h80);
        start_run(10, 20, 30, 40, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
        check("valid_latency", 80'(cyc), 80'd33);
        check("busy_cycles", 80'(bcyc), 80'd32);
        check("scale_x0", 80'(x0_o), 80'd100);
        check("scale_x7", 80'(x7_o), 80'd100);
        @(posedge clk); #1;
        check("valid_one_cycle", 80'(valid_o), 80'd0);

        // Saturation on neuron 0, then truncation of 64>>7 on neuron 1.
        for (int j = 0; j < 4; j++) wr(j, 8'hFF);
        for (int j = 0; j < 4; j++) wr(4 + j, 8'h40);
        start_run(255, 255, 255, 255, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
        check("sat_x0", 80'(x0_o), 80'd1023);
        start_run(1, 0, 0, 0, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
        check("trunc_x1", 80'(x1_o), 80'd0);

        // Mid-MAC write, start and input changes must all be ignored.
        write_all_w(8'h80);
        start_run(1, 2, 3, 4, 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        wr_en_i = 1'b1; wr_addr_i = 6'd9; wr_data_i = 8'hFF;
        start_i = 1'b1;
        in0_i = 8'd200; in1_i = 8'd200; in2_i = 8'd200; in3_i = 8'd200;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0; start_i = 1'b0;
        wait_done(cyc, bcyc);
        repeat (3) @(posedge clk);
        #1;
        check("no_queued_start", 80'(busy_o), 80'd0);
        check("hold_x", x_obs, last_exp);
        start_run(1, 2, 3, 4, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
        check("old_weight_x2", 80'(x2_o), 80'd10);

        // Reset at MAC cycle 15 aborts the run and clears all state.
        start_run(9, 9, 9, 9, 1'b0, 0, 0);
        repeat (14) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #2;
        check("rst_busy", 80'(busy_o), 80'd0);
        check("rst_x", x_obs, 80'd0);
        do_reset();
        nval = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) nval++;
        end
        @(posedge clk); #1;
        check("rst_no_valid", 80'(nval), 80'd0);
        start_run(5, 5, 5, 5, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
        check("rst_weights_zero", x_obs, 80'd0);

        // Bias on neuron 3, plus an unmapped write that must do nothing.
        write_all_w(8'h80);
        wr(35, 5);
        wr(45, 8'hFF);
        start_run(1, 1, 1, 1, 1'b0, 0, 0);
        wait_done(cyc, bcyc);
`ifdef HIDDEN_BIAS_EN
        check("bias_x3", 80'(x3_o), 80'd9);
`else
        check("bias_x3", 80'(x3_o), 80'd4);
`endif
        check("bias_x0", 80'(x0_o), 80'd4);

        // Write w[0][0] on the same edge that accepts start.
        write_all_w(0);
        start_run(7, 0, 0, 0, 1'b1, 0, 8'h80);
        wait_done(cyc, bcyc);
        check("simul_x0", 80'(x0_o), 80'd7);

        // start held high: back-to-back runs one IDLE cycle apart.
        in0_i = 8'd2; in1_i = 8'd2; in2_i = 8'd2; in3_i = 8'd2;
        start_i = 1'b1;
        push_expected(2, 2, 2, 2);
        push_expected(2, 2, 2, 2);
        v1 = 0;
        v2 = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (valid_o) begin
                if (v1 == 0) v1 = c;
                else begin
                    v2 = c;
                    start_i = 1'b0;
                    break;
                end
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_gap", 80'(v2 - v1), 80'd34);
        repeat (40) @(posedge clk);
        #1;
        check("b2b_drained", 80'(sb_q.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
